xcorr_pair_scheduler: RTL and testbench

- Sequences the shared cross-correlation core (XCORR_Top) over every microphone pair of one captured frame.
- Per pair: selects the two mic channels in the frame buffer, streams N samples into the core, collects the 2*LAG+1 correlation results, and reports the peak lag (TDOA) to the beamforming/localisation stage.
- Sits between the frame buffer / XCORR_Top and the direction-estimation logic.

---
 rtl/xcorr_sched_pkg.sv | 15 +
 rtl/xcorr_peak_finder.sv | 27 ++
 rtl/xcorr_pair_scheduler.sv | 129 ++++++++++++
 tb/tb_xcorr_pair_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/xcorr_sched_pkg.sv
// xcorr_sched_pkg: shared state encoding and sizing helpers for the xcorr pair scheduler
package xcorr_sched_pkg;
  typedef enum logic [2:0] {IDLE, STREAM, COLLECT, EMIT, GAP, DONE} state_t;
  // Never returns zero so single-pair / tiny configurations still get a 1-bit field
  function automatic int clogb2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
  function automatic int num_pairs(input int mics);
    return mics * (mics - 1) / 2;
  endfunction
  // Core emits lags -LAG..+LAG; result index k maps to lag k - LAG
  function automatic int num_results(input int lag);
    return 2 * lag + 1;
  endfunction
endpackage

// File: rtl/xcorr_peak_finder.sv
// xcorr_peak_finder: signed running argmax; ties keep the earliest index
module xcorr_peak_finder #(
  parameter int VW = 32,
  parameter int IW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 update,
  input  logic signed [VW-1:0] value,
  input  logic        [IW-1:0] index,
  output logic signed [VW-1:0] peak_val,
  output logic        [IW-1:0] peak_idx
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      peak_val <= '0;
      peak_idx <= '0;
    end else if (clear) begin
      peak_val <= '0;
      peak_idx <= '0;
    end else if (load || (update && value > peak_val)) begin
      peak_val <= value;
      peak_idx <= index;
    end
endmodule

// File: rtl/xcorr_pair_scheduler.sv
// xcorr_pair_scheduler: runs the shared xcorr core over every mic pair of a frame and reports each pair's peak lag
module xcorr_pair_scheduler
  import xcorr_sched_pkg::*;
#(
  parameter int W        = 16,
  parameter int N        = 1024,
  parameter int LAG      = 10,
  parameter int NUM_MICS = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      frame_ready,
  output logic                                      buf_rd_en,
  output logic [clogb2(N)-1:0]                      buf_rd_addr,
  output logic [clogb2(NUM_MICS)-1:0]               mic_sel_x,
  output logic [clogb2(NUM_MICS)-1:0]               mic_sel_y,
  output logic                                      xc_start,
  input  logic signed [2*W-1:0]                     xc_result,
  input  logic                                      xc_complete,
  output logic [clogb2(num_pairs(NUM_MICS))-1:0]    pair_idx,
  output logic signed [clogb2(LAG)+1:0]             peak_lag,
  output logic signed [2*W-1:0]                     peak_val,
  output logic                                      peak_valid,
  output logic                                      busy,
  output logic                                      frame_done,
  output logic                                      err_timeout,
  output logic                                      err_overrun
);
  localparam int NP = num_pairs(NUM_MICS);
  localparam int NR = num_results(LAG);
  localparam int AW = clogb2(N);
  localparam int MW = clogb2(NUM_MICS);
  localparam int PW = clogb2(NP);
  localparam int LW = clogb2(LAG) + 2;
  localparam int KW = clogb2(NR);
  localparam int CW = clogb2(TIMEOUT);
  state_t st, nxt;
  logic [AW-1:0] addr;
  logic [CW-1:0] cyc;
  logic [KW-1:0] k, f_idx;
  logic [MW-1:0] mx, my;
  logic [PW-1:0] pair;
  logic gap, xc_q, hit, last_k, tmo, last_pair;
  logic signed [2*W-1:0] f_val, held_val;
  logic signed [LW-1:0] lag_c, held_lag;
  assign hit       = st == COLLECT && xc_complete && !xc_q;
  assign last_k    = k == KW'(NR - 1);
  assign tmo       = cyc == CW'(TIMEOUT - 1);
  assign last_pair = mx == MW'(NUM_MICS - 2) && my == MW'(NUM_MICS - 1);
  assign lag_c     = LW'(f_idx) - LW'(LAG);
  xcorr_peak_finder #(.VW(2 * W), .IW(KW)) u_peak (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (st == IDLE && frame_ready),
    .load     (hit && k == '0),
    .update   (hit),
    .value    (xc_result),
    .index    (k),
    .peak_val (f_val),
    .peak_idx (f_idx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = frame_ready ? STREAM : IDLE;
      STREAM:  nxt = addr == AW'(N - 1) ? COLLECT : STREAM;
      COLLECT: nxt = hit && last_k ? EMIT : tmo ? GAP : COLLECT;
      EMIT:    nxt = GAP;
      GAP:     nxt = !gap ? GAP : last_pair ? DONE : STREAM;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    buf_rd_en   = st == STREAM;
    buf_rd_addr = addr;
    busy        = st != IDLE;
    frame_done  = st == DONE;
    peak_valid  = st == EMIT;
    // Hold the core until sample 0 arrives, one cycle behind address 0
    xc_start    = !((st == STREAM && addr != '0) || st == COLLECT || st == EMIT);
    mic_sel_x   = mx;
    mic_sel_y   = my;
    pair_idx    = pair;
    peak_val    = st == EMIT ? f_val : held_val;
    peak_lag    = st == EMIT ? lag_c : held_lag;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      xc_q        <= 1'b0;
      addr        <= '0;
      cyc         <= '0;
      k           <= '0;
      gap         <= 1'b0;
      mx          <= '0;
      my          <= '0;
      pair        <= '0;
      held_val    <= '0;
      held_lag    <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      xc_q <= xc_complete;
      addr <= st == STREAM && addr != AW'(N - 1) ? addr + AW'(1) : '0;
      cyc  <= st == COLLECT ? cyc + CW'(1) : '0;
      k    <= st == COLLECT ? k + KW'(hit) : '0;
      gap  <= st == GAP && !gap;
      if (st == IDLE && frame_ready) begin
        err_timeout <= 1'b0;
        err_overrun <= 1'b0;
        pair        <= '0;
        mx          <= '0;
        my          <= MW'(1);
      end else if (frame_ready) err_overrun <= 1'b1;
      if (st == COLLECT && tmo && !(hit && last_k)) err_timeout <= 1'b1;
      if (st == EMIT) begin
        held_val <= f_val;
        held_lag <= lag_c;
      end
      // Nested pair counters: y sweeps above x, then x advances and y restarts at x+1
      if (st == GAP && gap && !last_pair) begin
        pair <= pair + PW'(1);
        mx   <= my == MW'(NUM_MICS - 1) ? mx + MW'(1) : mx;
        my   <= my == MW'(NUM_MICS - 1) ? mx + MW'(2) : my + MW'(1);
      end
    end
endmodule

// File: tb/tb_xcorr_pair_scheduler.sv
// tb_xcorr_pair_scheduler: directed frames with random correlation data against a reference argmax model
module tb_xcorr_pair_scheduler;
  localparam int W = 16, N = 1024, LAG = 10, M = 4, TIMEOUT = 4096;
  localparam int NP = M * (M - 1) / 2, NR = 2 * LAG + 1;
  localparam int LIMIT = NP * (N + 200) + TIMEOUT + 500;
  logic clk = 0, rst_n = 0, frame_ready = 0, xc_complete = 0;
  logic signed [2*W-1:0] xc_result = 0;
  logic buf_rd_en, xc_start, peak_valid, busy, frame_done, err_timeout, err_overrun;
  logic [9:0] buf_rd_addr;
  logic [1:0] mic_sel_x, mic_sel_y;
  logic [2:0] pair_idx;
  logic signed [5:0] peak_lag;
  logic signed [2*W-1:0] peak_val;
  int total = 0, bad = 0;
  logic signed [31:0] res [NP][NR];
  int nres [NP];
  int exp_lag [NP];
  logic signed [31:0] exp_val [NP];
  int px [NP], py [NP];
  int mp = 0;
  logic pe = 0, pb = 0;
  int to_lat;

  xcorr_pair_scheduler #(.W(W), .N(N), .LAG(LAG), .NUM_MICS(M), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .frame_ready(frame_ready), .buf_rd_en(buf_rd_en),
    .buf_rd_addr(buf_rd_addr), .mic_sel_x(mic_sel_x), .mic_sel_y(mic_sel_y),
    .xc_start(xc_start), .xc_result(xc_result), .xc_complete(xc_complete),
    .pair_idx(pair_idx), .peak_lag(peak_lag), .peak_val(peak_val), .peak_valid(peak_valid),
    .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Core model: after each streaming burst, emit this pair's results with random spacing
  initial forever begin
    @(negedge clk);
    if (busy && !pb) mp = 0;
    if (pe && !buf_rd_en) begin
      for (int k = 0; k < nres[mp]; k++) begin
        repeat ($urandom_range(3, 1)) @(negedge clk);
        xc_result = res[mp][k];
        xc_complete = 1;
        @(negedge clk);
        xc_complete = 0;
      end
      mp = (mp + 1) % NP;
    end
    pe = buf_rd_en;
    pb = busy;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_rand();
    for (int p = 0; p < NP; p++) begin
      nres[p] = NR;
      for (int k = 0; k < NR; k++) res[p][k] = $urandom;
    end
  endtask

  task automatic calc();
    for (int p = 0; p < NP; p++) begin
      int best = 0;
      for (int k = 1; k < NR; k++) if (res[p][k] > res[p][best]) best = k;
      exp_lag[p] = best - LAG;
      exp_val[p] = res[p][best];
    end
  endtask

  task automatic run_frame(input int ovr_at, input int rst_pair, output int lat);
    int ea = 0, pe_cnt = 0, gap = 0, npv = 0, nbad = 0, last_en = 0, cyc = 0, exp_pv = 0, fd = 0, pi;
    logic pen = 0, pto = 0, stop = 0;
    lat = -1;
    for (int p = 0; p < NP; p++) exp_pv += (nres[p] == NR) ? 1 : 0;
    @(negedge clk);
    frame_ready = 1;
    @(negedge clk);
    frame_ready = 0;
    chk("accept_busy", busy, 1);
    chk("start_pair", pair_idx, 0);
    chk("err_cleared", {err_overrun, err_timeout}, 0);
    while (!stop && cyc < LIMIT) begin
      if (buf_rd_en) begin
        if (pe_cnt >= NP || int'(buf_rd_addr) != ea || int'(mic_sel_x) != px[pe_cnt] || int'(mic_sel_y) != py[pe_cnt]) nbad++;
        if (xc_start !== (ea == 0)) nbad++;
        if (ea == 0 && pe_cnt > 0) chk("gap_xc_start", gap, 2);
        gap = 0;
        ea++;
      end else if (busy && xc_start) gap++;
      if (pen && !buf_rd_en) begin
        chk("addr_count", ea, N);
        chk("xc_start_collect", xc_start, 0);
        ea = 0;
        pe_cnt++;
        last_en = cyc;
      end
      if (err_timeout && !pto) lat = cyc - last_en;
      if (peak_valid) begin
        pi = pe_cnt > 0 ? pe_cnt - 1 : 0;
        npv++;
        chk("pair_idx", pair_idx, pe_cnt - 1);
        chk("peak_lag", peak_lag, exp_lag[pi]);
        chk("peak_val", peak_val, exp_val[pi]);
      end
      if (frame_done) begin
        fd++;
        stop = 1;
      end
      if (rst_pair >= 0 && pe_cnt == rst_pair + 1 && cyc == last_en + 8) stop = 1;
      frame_ready = (cyc == ovr_at);
      pen = buf_rd_en;
      pto = err_timeout;
      if (!stop) begin
        @(negedge clk);
        cyc++;
      end
    end
    frame_ready = 0;
    if (rst_pair >= 0) begin
      rst_n = 0;
      #1;
      chk("rst_xc_start", xc_start, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", buf_rd_en, 0);
      chk("rst_pairs_before", npv, rst_pair);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (150) begin
        @(negedge clk);
        if (frame_done || peak_valid) fd++;
      end
      chk("rst_no_done", fd, 0);
    end else begin
      chk("frame_done", fd, 1);
      chk("pairs_streamed", pe_cnt, NP);
      chk("peak_valid_count", npv, exp_pv);
      chk("stream_errs", nbad, 0);
    end
  endtask

  initial begin
    int n = 0;
    for (int a = 0; a < M; a++)
      for (int b = a + 1; b < M; b++) begin
        px[n] = a;
        py[n] = b;
        n++;
      end
    fill_rand();
    repeat (3) @(negedge clk);
    chk("reset_xc_start", xc_start, 1);
    chk("reset_outputs_zero", |{buf_rd_en, buf_rd_addr, mic_sel_x, mic_sel_y, pair_idx, peak_lag,
        peak_val, peak_valid, busy, frame_done, err_timeout, err_overrun}, 0);
    rst_n = 1;
    @(negedge clk);
    // Frame 1: single dominant peak and a negative tie at both lag extremes
    fill_rand();
    for (int k = 0; k < NR; k++) begin
      res[0][k] = 10;
      res[1][k] = -7 - $urandom_range(1000, 1);
    end
    res[0][13] = 500;
    res[1][0] = -7;
    res[1][NR-1] = -7;
    calc();
    chk("model_peak_plus3", exp_lag[0], 3);
    chk("model_tie_minus10", exp_lag[1], -10);
    run_frame(-1, -1, to_lat);
    // Frame 2: frame_ready while busy
    fill_rand();
    calc();
    run_frame(300, -1, to_lat);
    chk("overrun_flag", err_overrun, 1);
    // Frame 3: core stalls after 15 results on pair 3
    fill_rand();
    nres[3] = 15;
    calc();
    run_frame(-1, -1, to_lat);
    chk("timeout_flag", err_timeout, 1);
    chk("timeout_latency_ok", (to_lat >= TIMEOUT - 1 && to_lat <= TIMEOUT + 1), 1);
    // Frame 4: reset during COLLECT of pair 2
    fill_rand();
    calc();
    run_frame(-1, 2, to_lat);
    // Frame 5: clean restart from pair 0
    fill_rand();
    calc();
    run_frame(-1, -1, to_lat);
    chk("final_no_errors", {err_overrun, err_timeout}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
